pll_mdrp_ctrl: RTL and testbench

PLL_MDRP_CTRL -- requirements
Module: pll_mdrp_ctrl

---
 rtl/pll_mdrp_pkg.sv | 23 ++
 rtl/pll_mdrp_ctrl_if.sv | 24 ++
 rtl/cdc_sync2.sv | 32 +++
 rtl/pll_mdrp_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pll_mdrp_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_mdrp_pkg.sv
// pll_mdrp_pkg -- shared definitions for the PLL MDRP reconfiguration controller.
//   mdopc_e : opcode driven on the PLL mdopc pins
//   state_e : controller FSM states
package pll_mdrp_pkg;

  // MDRP opcode encoding; ADDR-LOAD carries the target address on mdwdi.
  typedef enum logic [1:0] {
    OPC_NOP   = 2'b00,
    OPC_WRITE = 2'b01,
    OPC_READ  = 2'b10,
    OPC_ALOAD = 2'b11
  } mdopc_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_OP       = 3'd2,
    ST_RDWAIT   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_LOCKWAIT = 3'd5
  } state_e;

endpackage

// File: rtl/pll_mdrp_ctrl_if.sv
// pll_mdrp_ctrl_if -- command/response bus of the PLL MDRP controller.
//   cmd_valid/cmd_ready handshake with cmd_write, cmd_addr, cmd_wdata, cmd_last;
//   rsp_valid (one-cycle pulse) with rsp_rdata for read results.
//   master : command issuer, slave : controller.
interface pll_mdrp_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       cmd_last;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_last,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_last,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/cdc_sync2.sv
// cdc_sync2 -- two-flop synchroniser for a single asynchronous level.
//   clk, rst_n : destination clock and async active-low reset
//   d          : asynchronous input
//   q          : synchronised output, two clk edges after d
module cdc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-value logic for the synchroniser chain.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/pll_mdrp_ctrl.sv
// pll_mdrp_ctrl -- sequences PLL MDRP reads/writes and the post-write PLL
// reset / lock handshake.
//   clk, rst_n          : system clock (also PLL mdclk), async active-low reset
//   bus (slave)         : command/response bus
//   mdopc/mdainc/mdwdi  : MDRP opcode, address auto-increment, write data/address
//   mdrdo               : MDRP read data, valid RD_LATENCY cycles after READ
//   pll_reset/pll_lock  : PLL reset out, asynchronous lock in
//   locked, timeout_err : synchronised lock status, sticky lock timeout
// RD_LATENCY and RST_HOLD are expected to be at least 1.
module pll_mdrp_ctrl
  import pll_mdrp_pkg::*;
#(
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned LOCK_TIMEOUT = 1_000_000,
  parameter int unsigned RST_HOLD     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_mdrp_ctrl_if.slave        bus,
  output logic [1:0]            mdopc,
  output logic                  mdainc,
  output logic [7:0]            mdwdi,
  input  logic [7:0]            mdrdo,
  output logic                  pll_reset,
  input  logic                  pll_lock,
  output logic                  locked,
  output logic                  timeout_err
);
  localparam int unsigned TO_W     = (LOCK_TIMEOUT > 32'd1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int unsigned WAIT_MAX = (RST_HOLD > RD_LATENCY) ? RST_HOLD : RD_LATENCY;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 32'd1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 32'd1);
  localparam logic [WAIT_W-1:0] HOLD_LAST = WAIT_W'(RST_HOLD - 32'd1);
  localparam logic [WAIT_W-1:0] RD_LAST   = WAIT_W'(RD_LATENCY - 32'd1);

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              write_q, write_d;
  logic              last_q, last_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        cur_addr_q, cur_addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  mdopc_e            mdopc_q, mdopc_d;
  logic              mdainc_q, mdainc_d;
  logic [7:0]        mdwdi_q, mdwdi_d;
  logic              pll_reset_q, pll_reset_d;
  logic              timeout_err_q, timeout_err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_rdata_q, rsp_rdata_d;
  logic              lock_s;
  logic [7:0]        next_addr_s;

  cdc_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // 8-bit add wraps 255 -> 0, matching the PLL's own auto-increment.
  assign next_addr_s = cur_addr_q + 8'd1;

  // Next-state and next-output logic; MDRP outputs are computed for the
  // state being entered so the registered pins line up with state_q.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    last_d        = last_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cur_addr_d    = cur_addr_q;
    addr_valid_d  = addr_valid_q;
    wait_cnt_d    = wait_cnt_q;
    to_cnt_d      = to_cnt_q;
    pll_reset_d   = pll_reset_q;
    timeout_err_d = timeout_err_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_valid_d   = 1'b0;
    mdopc_d       = OPC_NOP;
    mdainc_d      = 1'b0;
    mdwdi_d       = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          write_d = bus.cmd_write;
          last_d  = bus.cmd_last;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          if (bus.cmd_write) begin
            pll_reset_d   = 1'b1;
            timeout_err_d = 1'b0;
          end else begin
            pll_reset_d   = pll_reset_q;
          end
          if (addr_valid_q && (bus.cmd_addr == next_addr_s)) begin
            // Sequential address: skip the ADDR-LOAD and let the PLL increment.
            state_d    = ST_OP;
            cur_addr_d = bus.cmd_addr;
            mdainc_d   = 1'b1;
            mdopc_d    = bus.cmd_write ? OPC_WRITE : OPC_READ;
            mdwdi_d    = bus.cmd_write ? bus.cmd_wdata : 8'h00;
          end else begin
            state_d = ST_ADDR;
            mdopc_d = OPC_ALOAD;
            mdwdi_d = bus.cmd_addr;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        state_d      = ST_OP;
        cur_addr_d   = addr_q;
        addr_valid_d = 1'b1;
        mdopc_d      = write_q ? OPC_WRITE : OPC_READ;
        mdwdi_d      = write_q ? wdata_q : 8'h00;
      end
      ST_OP: begin
        wait_cnt_d = {WAIT_W{1'b0}};
        if (write_q) begin
          state_d = last_q ? ST_HOLD : ST_IDLE;
        end else begin
          state_d = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        if (wait_cnt_q == RD_LAST) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mdrdo;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (wait_cnt_q == HOLD_LAST) begin
          state_d     = ST_LOCKWAIT;
          pll_reset_d = 1'b0;
          to_cnt_d    = {TO_W{1'b0}};
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_LOCKWAIT: begin
        if (lock_s) begin
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          // Only incremented below TO_LAST, so the counter never wraps.
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      write_q       <= 1'b0;
      last_q        <= 1'b0;
      addr_q        <= 8'h00;
      wdata_q       <= 8'h00;
      cur_addr_q    <= 8'h00;
      addr_valid_q  <= 1'b0;
      wait_cnt_q    <= {WAIT_W{1'b0}};
      to_cnt_q      <= {TO_W{1'b0}};
      mdopc_q       <= OPC_NOP;
      mdainc_q      <= 1'b0;
      mdwdi_q       <= 8'h00;
      pll_reset_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      write_q       <= write_d;
      last_q        <= last_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cur_addr_q    <= cur_addr_d;
      addr_valid_q  <= addr_valid_d;
      wait_cnt_q    <= wait_cnt_d;
      to_cnt_q      <= to_cnt_d;
      mdopc_q       <= mdopc_d;
      mdainc_q      <= mdainc_d;
      mdwdi_q       <= mdwdi_d;
      pll_reset_q   <= pll_reset_d;
      timeout_err_q <= timeout_err_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign mdopc         = mdopc_q;
  assign mdainc        = mdainc_q;
  assign mdwdi         = mdwdi_q;
  assign pll_reset     = pll_reset_q;
  assign timeout_err   = timeout_err_q;
  // Lock is only reported once the PLL is out of reset and settled.
  assign locked = lock_s && !pll_reset_q && (state_q != ST_LOCKWAIT) && (state_q != ST_HOLD);
endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// tb_pll_mdrp_ctrl -- directed self-checking bench for pll_mdrp_ctrl
// (RD_LATENCY=2, LOCK_TIMEOUT=100, RST_HOLD=16).
module tb_pll_mdrp_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;
  logic       pll_reset;
  logic       pll_lock;
  logic       locked;
  logic       timeout_err;

  int compared   = 0;
  int mismatched = 0;

  // Every non-NOP MDRP cycle as {mdopc, mdainc, mdwdi}.
  logic [10:0] log_q[$];

  pll_mdrp_ctrl_if bus ();

  pll_mdrp_ctrl #(
    .RD_LATENCY   (2),
    .LOCK_TIMEOUT (100),
    .RST_HOLD     (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mdopc       (mdopc),
    .mdainc      (mdainc),
    .mdwdi       (mdwdi),
    .mdrdo       (mdrdo),
    .pll_reset   (pll_reset),
    .pll_lock    (pll_lock),
    .locked      (locked),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mdopc !== 2'b00) log_q.push_back({mdopc, mdainc, mdwdi});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time got %0t want below 100000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] d, input logic l);
    bit ok;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_last  = l;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    compared++;
    if (!ok) begin mismatched++; $display("FAIL cmd_accept: cmd_ready got %b want 1 (addr %h)", bus.cmd_ready, a); end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_lock = 1'b0; mdrdo = 8'h00;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h00; bus.cmd_wdata = 8'h00; bus.cmd_last = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (bus.cmd_ready !== 1'b0) begin mismatched++; $display("FAIL rst_cmd_ready: got %b want 0", bus.cmd_ready); end
    compared++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== 9'h000) begin mismatched++; $display("FAIL rst_rsp: got %h want 000", {bus.rsp_valid, bus.rsp_rdata}); end
    compared++;
    if ({mdopc, mdainc, mdwdi} !== 11'h000) begin mismatched++; $display("FAIL rst_mdrp: got %h want 000", {mdopc, mdainc, mdwdi}); end
    compared++;
    if ({pll_reset, locked, timeout_err} !== 3'b000) begin mismatched++; $display("FAIL rst_pll: got %b want 000", {pll_reset, locked, timeout_err}); end
    rst_n = 1'b1;
    #1;
    compared++;
    if (bus.cmd_ready !== 1'b0) begin mismatched++; $display("FAIL rel_ready_pre_edge: got %b want 0", bus.cmd_ready); end
    @(negedge clk);
    compared++;
    if (bus.cmd_ready !== 1'b1) begin mismatched++; $display("FAIL rel_ready_post_edge: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_write_lock();
    int k;
    logic [10:0] exp_log [2];
    exp_log[0] = {2'b11, 1'b0, 8'h10};
    exp_log[1] = {2'b01, 1'b0, 8'hA5};
    log_q.delete();
    send_cmd(1'b1, 8'h10, 8'hA5, 1'b1);
    k = 0;
    @(negedge clk);
    while (pll_reset === 1'b1 && k < 60) begin k++; @(negedge clk); end
    compared++;
    if (k != 18) begin mismatched++; $display("FAIL wl_reset_len: got %0d want 18", k); end
    compared++;
    if ({locked, bus.cmd_ready} !== 2'b00) begin mismatched++; $display("FAIL wl_lockwait: locked,ready got %b want 00", {locked, bus.cmd_ready}); end
    repeat (4) @(negedge clk);
    pll_lock = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (bus.cmd_ready !== 1'b1 && k < 20);
    compared++;
    if (k != 3) begin mismatched++; $display("FAIL wl_lock_latency: got %0d want 3", k); end
    compared++;
    if ({locked, timeout_err} !== 2'b10) begin mismatched++; $display("FAIL wl_locked: locked,err got %b want 10", {locked, timeout_err}); end
    compared++;
    if (log_q.size() != 2) begin mismatched++; $display("FAIL wl_op_count: got %0d want 2", log_q.size()); end
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (i >= log_q.size() || log_q[i] !== exp_log[i]) begin mismatched++; $display("FAIL wl_op%0d: got %h want %h", i, (i < log_q.size()) ? log_q[i] : 11'h7FF, exp_log[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_log [4];
    exp_log[0] = {2'b11, 1'b0, 8'h20};
    exp_log[1] = {2'b01, 1'b0, 8'h11};
    exp_log[2] = {2'b01, 1'b1, 8'h22};
    exp_log[3] = {2'b01, 1'b1, 8'h33};
    log_q.delete();
    send_cmd(1'b1, 8'h20, 8'h11, 1'b0);
    send_cmd(1'b1, 8'h21, 8'h22, 1'b0);
    send_cmd(1'b1, 8'h22, 8'h33, 1'b0);
    repeat (3) @(negedge clk);
    compared++;
    if ({pll_reset, locked, bus.cmd_ready} !== 3'b101) begin mismatched++; $display("FAIL b2b_status: rst,locked,ready got %b want 101", {pll_reset, locked, bus.cmd_ready}); end
    compared++;
    if (log_q.size() != 4) begin mismatched++; $display("FAIL b2b_op_count: got %0d want 4", log_q.size()); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (i >= log_q.size() || log_q[i] !== exp_log[i]) begin mismatched++; $display("FAIL b2b_op%0d: got %h want %h", i, (i < log_q.size()) ? log_q[i] : 11'h7FF, exp_log[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [10:0] exp_log [3];
    exp_log[0] = {2'b11, 1'b0, 8'hFF};
    exp_log[1] = {2'b01, 1'b0, 8'h5A};
    exp_log[2] = {2'b01, 1'b1, 8'h6B};
    log_q.delete();
    send_cmd(1'b1, 8'hFF, 8'h5A, 1'b0);
    send_cmd(1'b1, 8'h00, 8'h6B, 1'b0);
    repeat (3) @(negedge clk);
    compared++;
    if (log_q.size() != 3) begin mismatched++; $display("FAIL wrap_op_count: got %0d want 3", log_q.size()); end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (i >= log_q.size() || log_q[i] !== exp_log[i]) begin mismatched++; $display("FAIL wrap_op%0d: got %h want %h", i, (i < log_q.size()) ? log_q[i] : 11'h7FF, exp_log[i]); end
    end
  endtask

  task automatic test_read();
    int k;
    logic [10:0] exp_log [2];
    exp_log[0] = {2'b11, 1'b0, 8'h05};
    exp_log[1] = {2'b10, 1'b0, 8'h00};
    log_q.delete();
    mdrdo = 8'hC3;
    send_cmd(1'b0, 8'h05, 8'h00, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (mdopc !== 2'b10 && k < 10);
    compared++;
    if (k != 2) begin mismatched++; $display("FAIL rd_op_cycle: got %0d want 2", k); end
    @(negedge clk);
    mdrdo = 8'h3C;
    compared++;
    if (bus.rsp_valid !== 1'b0) begin mismatched++; $display("FAIL rd_early1: rsp_valid got %b want 0", bus.rsp_valid); end
    @(negedge clk);
    compared++;
    if (bus.rsp_valid !== 1'b0) begin mismatched++; $display("FAIL rd_early2: rsp_valid got %b want 0", bus.rsp_valid); end
    @(negedge clk);
    compared++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== 9'h13C) begin mismatched++; $display("FAIL rd_rsp: valid,data got %h want 13c", {bus.rsp_valid, bus.rsp_rdata}); end
    compared++;
    if (pll_reset !== 1'b1) begin mismatched++; $display("FAIL rd_pll_reset: got %b want 1", pll_reset); end
    mdrdo = 8'hEE;
    @(negedge clk);
    compared++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin mismatched++; $display("FAIL rd_pulse_end: valid,ready got %b want 01", {bus.rsp_valid, bus.cmd_ready}); end
    compared++;
    if (log_q.size() != 2) begin mismatched++; $display("FAIL rd_op_count: got %0d want 2", log_q.size()); end
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (i >= log_q.size() || log_q[i] !== exp_log[i]) begin mismatched++; $display("FAIL rd_op%0d: got %h want %h", i, (i < log_q.size()) ? log_q[i] : 11'h7FF, exp_log[i]); end
    end
  endtask

  task automatic test_timeout();
    int k;
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    log_q.delete();
    send_cmd(1'b1, 8'h06, 8'h99, 1'b1);
    k = 0;
    @(negedge clk);
    while (pll_reset === 1'b1 && k < 60) begin k++; @(negedge clk); end
    compared++;
    if (k != 17) begin mismatched++; $display("FAIL to_reset_len: got %0d want 17", k); end
    k = 0;
    while (timeout_err !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    compared++;
    if (k != 100) begin mismatched++; $display("FAIL to_cycles: got %0d want 100", k); end
    compared++;
    if ({bus.cmd_ready, locked} !== 2'b10) begin mismatched++; $display("FAIL to_idle: ready,locked got %b want 10", {bus.cmd_ready, locked}); end
    compared++;
    if (log_q.size() != 1 || log_q[0] !== {2'b01, 1'b1, 8'h99}) begin mismatched++; $display("FAIL to_ops: got %0d ops first %h want 1 op %h", log_q.size(), (log_q.size() > 0) ? log_q[0] : 11'h7FF, {2'b01, 1'b1, 8'h99}); end
    send_cmd(1'b0, 8'h40, 8'h00, 1'b0);
    repeat (6) @(negedge clk);
    compared++;
    if ({timeout_err, pll_reset} !== 2'b10) begin mismatched++; $display("FAIL to_after_read: err,rst got %b want 10", {timeout_err, pll_reset}); end
    send_cmd(1'b1, 8'h41, 8'h01, 1'b0);
    @(negedge clk);
    compared++;
    if ({timeout_err, pll_reset, mdopc, mdainc} !== 5'b01011) begin mismatched++; $display("FAIL to_clear: err,rst,opc,ainc got %b want 01011", {timeout_err, pll_reset, mdopc, mdainc}); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    logic [10:0] exp_log [2];
    exp_log[0] = {2'b11, 1'b0, 8'h51};
    exp_log[1] = {2'b01, 1'b0, 8'h77};
    send_cmd(1'b1, 8'h50, 8'h0F, 1'b1);
    repeat (7) @(negedge clk);
    compared++;
    if (pll_reset !== 1'b1) begin mismatched++; $display("FAIL mh_in_hold: pll_reset got %b want 1", pll_reset); end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({pll_reset, mdopc, mdainc, mdwdi} !== 12'h000) begin mismatched++; $display("FAIL mh_async: rst,opc,ainc,wdi got %h want 000", {pll_reset, mdopc, mdainc, mdwdi}); end
    compared++;
    if ({bus.cmd_ready, bus.rsp_valid, timeout_err} !== 3'b000) begin mismatched++; $display("FAIL mh_async_ctl: ready,rsp,err got %b want 000", {bus.cmd_ready, bus.rsp_valid, timeout_err}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if (bus.cmd_ready !== 1'b0) begin mismatched++; $display("FAIL mh_ready_pre_edge: got %b want 0", bus.cmd_ready); end
    @(negedge clk);
    compared++;
    if ({bus.cmd_ready, pll_reset} !== 2'b10) begin mismatched++; $display("FAIL mh_idle: ready,rst got %b want 10", {bus.cmd_ready, pll_reset}); end
    repeat (20) @(negedge clk);
    compared++;
    if ({bus.cmd_ready, pll_reset, mdopc} !== 4'b1000) begin mismatched++; $display("FAIL mh_no_resume: ready,rst,opc got %b want 1000", {bus.cmd_ready, pll_reset, mdopc}); end
    log_q.delete();
    send_cmd(1'b1, 8'h51, 8'h77, 1'b0);
    repeat (3) @(negedge clk);
    compared++;
    if (log_q.size() != 2) begin mismatched++; $display("FAIL mh_op_count: got %0d want 2", log_q.size()); end
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (i >= log_q.size() || log_q[i] !== exp_log[i]) begin mismatched++; $display("FAIL mh_op%0d: got %h want %h", i, (i < log_q.size()) ? log_q[i] : 11'h7FF, exp_log[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_lock();
    test_back_to_back();
    test_wrap();
    test_read();
    test_timeout();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
